// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, word-organised instruction memory
// loaded by the debug unit, and an IDLE/RUN/HALTED control FSM with fetch counter.
module if_fetch_stage #(
  parameter int unsigned SIZE_DATA = 32,
  parameter int unsigned ADDR_W    = 6,
  parameter logic [SIZE_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_start,
  input  logic                 i_stall,
  input  logic                 i_branch_taken,
  input  logic [SIZE_DATA-1:0] i_branch_target,
  input  logic                 i_load_wr,
  input  logic [ADDR_W-1:0]    i_load_addr,
  input  logic [SIZE_DATA-1:0] i_load_data,
  output logic [SIZE_DATA-1:0] o_pc,
  output logic [SIZE_DATA-1:0] o_instruction,
  output logic                 o_valid,
  output logic                 o_halted,
  output logic [SIZE_DATA-1:0] o_pc_current,
  output logic [CNT_W-1:0]     o_fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [SIZE_DATA-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SIZE_DATA-1:0] mem [2**ADDR_W];
  logic [SIZE_DATA-1:0] mem_rd;

  // Byte-address PC; low two bits and bits above the array depth are dropped so fetches wrap.
  assign mem_rd = mem[pc_q[ADDR_W+1:2]];

  // Loading is only legal while the pipeline is parked, regardless of the run gate.
  always_ff @(posedge i_clk) begin
    if (i_load_wr && state_q == ST_IDLE) begin
      mem[i_load_addr] <= i_load_data;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (i_enable) begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) state_d = ST_RUN;
        end
        ST_RUN: begin
          // A taken branch squashes whatever sits at the current PC, including HALT.
          if (i_branch_taken) begin
            pc_d  = i_branch_target;
            cnt_d = cnt_q + CNT_W'(1);
          end else if (i_stall) begin
            pc_d = pc_q;
          end else if (mem_rd == HALT_WORD) begin
            state_d = ST_HALTED;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            pc_d  = pc_q + SIZE_DATA'(4);
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_HALTED: begin
          state_d = ST_HALTED;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_pc          = pc_q + SIZE_DATA'(4);
  assign o_instruction = (state_q == ST_RUN) ? mem_rd : '0;
  assign o_valid       = (state_q == ST_RUN);
  assign o_halted      = (state_q == ST_HALTED);
  assign o_pc_current  = pc_q;
  assign o_fetch_count = cnt_q;

endmodule
